mul_operand_feeder: RTL

Upstream sequencer for the repeated-addition multiplier datapath/controller pair. It accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry FIFO. For each pair it clears and starts the multiplier, time-multiplexes A then B onto the multiplier's shared 16-bit data input, waits for `done`, and returns the product over a valid/ready result port. It sits between the operand source (bench or bus adapter) and the multiplier, so the multiplier never needs hand-timed stimulus.

---
 rtl/mul_feeder_pkg.sv | 17 +
 rtl/mul_feeder_fifo.sv | 67 ++++++
 rtl/mul_operand_feeder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mul_feeder_pkg.sv
// Shared types and constants for the multiplier operand feeder.
package mul_feeder_pkg;

    localparam int MUL_FEEDER_WIDTH      = 16;
    localparam int MUL_FEEDER_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_LDA,
        ST_LDB,
        ST_WAIT,
        ST_RESULT
    } mul_feeder_state_t;

endpackage

// File: rtl/mul_feeder_fifo.sv
// Two-entry synchronous FIFO holding {a, b} operand pairs for the feeder.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mul_feeder_fifo
    import mul_feeder_pkg::*;
#(
    parameter int   WIDTH = MUL_FEEDER_WIDTH,
    localparam int  DEPTH = MUL_FEEDER_FIFO_DEPTH,
    localparam int  PTR_W = $clog2(DEPTH),
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a,
    input  logic [WIDTH-1:0] push_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head_a,
    output logic [WIDTH-1:0] head_b,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_a  = mem_a[rd_ptr];
    assign head_b  = mem_b[rd_ptr];

    // Operand storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a[wr_ptr] <= push_a;
            mem_b[wr_ptr] <= push_b;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Sequencer that feeds operand pairs to the repeated-addition multiplier and
// returns its product over a valid/ready port.
// Optional build macro: MUL_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts a job after TIMEOUT_CYCLES and flags it on out_err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a FIFO head; zero operand -> bypass to RESULT
// ST_CLR    | mul_clr pulse, multiplier back to its initial state
// ST_START  | mul_start pulse with A on mul_data
// ST_LDA    | A held on mul_data
// ST_LDB    | B on mul_data
// ST_WAIT   | B held, waiting for mul_done (or watchdog expiry)
// ST_RESULT | out_valid high until the consumer takes the product
module mul_operand_feeder
    import mul_feeder_pkg::*;
#(
    parameter int WIDTH          = MUL_FEEDER_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mul_clr,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_data,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    mul_feeder_state_t state;

    logic                                       fifo_pop;
    logic                                       fifo_full;
    logic                                       fifo_empty;
    logic [WIDTH-1:0]                           head_a;
    logic [WIDTH-1:0]                           head_b;
    logic [$clog2(MUL_FEEDER_FIFO_DEPTH+1)-1:0] fifo_count_unused;
    logic                                       head_zero;
    logic                                       wait_timeout;

    assign in_ready  = !fifo_full;
    assign head_zero = (head_a == '0) || (head_b == '0);

    // The head leaves the FIFO exactly when the FSM moves into RESULT.
    assign fifo_pop = ((state == ST_IDLE) && !fifo_empty && head_zero) ||
                      ((state == ST_WAIT) && (mul_done || wait_timeout));

    mul_feeder_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_valid && in_ready),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (fifo_pop),
        .head_a (head_a),
        .head_b (head_b),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count_unused)
    );

`ifdef MUL_FEEDER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;
    logic             err_q;

    assign wait_timeout = (state == ST_WAIT) && !mul_done && (tmr == '0);
    assign out_err      = err_q;

    // Watchdog down-counter, reloaded on the way into WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state == ST_LDB) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if ((state == ST_WAIT) && (tmr != '0)) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    // Abort flag travels with the zeroed result and clears on hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wait_timeout) begin
            err_q <= 1'b1;
        end else if ((state == ST_RESULT) && out_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wait_timeout       = 1'b0;
    assign out_err            = 1'b0;
`endif

    // Job sequencing with registered multiplier controls and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mul_clr   <= 1'b0;
            mul_start <= 1'b0;
            mul_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            mul_clr   <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_zero) begin
                            state     <= ST_RESULT;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                        end else begin
                            state   <= ST_CLR;
                            mul_clr <= 1'b1;
                        end
                    end
                end
                ST_CLR: begin
                    state     <= ST_START;
                    mul_start <= 1'b1;
                    mul_data  <= head_a;
                end
                ST_START: begin
                    state    <= ST_LDA;
                    mul_data <= head_a;
                end
                ST_LDA: begin
                    state    <= ST_LDB;
                    mul_data <= head_b;
                end
                ST_LDB: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        state     <= ST_RESULT;
                        out_valid <= 1'b1;
                        out_data  <= mul_product;
                        mul_data  <= '0;
                    end else if (wait_timeout) begin
                        state     <= ST_RESULT;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        mul_data  <= '0;
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mul_data  <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
